// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-delivery side of the console UART receiver.
//
// Handshake: the receiver (master) raises rx_valid with rx_data when a byte is
// complete and holds both stable until a clk edge where rx_valid and rx_ready
// are both 1; that edge transfers the byte. rx_ready is don't-care while
// rx_valid is 0. overrun and frame_err are single-cycle status pulses.
//
// Signals:
//   rx_data   master->slave  8  received byte
//   rx_valid  master->slave  1  rx_data holds an unconsumed byte
//   rx_ready  slave->master  1  consumer accepts the byte
//   overrun   master->slave  1  pulse: new byte discarded, old byte kept
//   frame_err master->slave  1  pulse: bad stop bit (or bad parity)
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output overrun,
    output frame_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  overrun,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver for the console UART, 8N1, LSB first,
// 16x oversampling. Received bytes leave through uart_rx_if (master side).
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (even parity bit
// between data and stop; a mismatch pulses frame_err and drops the byte).
//
// Parameters:
//   CLOCK  system clock in MHz
//   BAUD   line rate in bit/s
// Ports:
//   clk        system clock, posedge
//   rst        synchronous reset, active-high
//   rxd        serial line, idle high, asynchronous to clk
//   rx_if      byte handshake + error pulses (master modport)
//   state_dbg  current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4 WAIT_IDLE=5)
module uart_rx #(
  parameter int CLOCK = 50,
  parameter int BAUD  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  uart_rx_if.master  rx_if,
  output logic [2:0] state_dbg
);

  // Oversample tick period, rounded down.
  localparam int DIV = (CLOCK * 1_000_000) / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          state;
  logic            rxd_meta;
  logic            rxd_s;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic            bit_end;
  logic [3:0]      os;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            overrun;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_bad;
`endif

  assign tick    = (tick_cnt == CW'(DIV - 1));
  // One full bit after the previous sample point (os wraps 15 -> 0 by itself).
  assign bit_end = tick && (os == 4'd15);

  assign rx_if.rx_data   = rx_data;
  assign rx_if.rx_valid  = rx_valid;
  assign rx_if.overrun   = overrun;
  assign rx_if.frame_err = frame_err;
  assign state_dbg       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rxd_meta  <= 1'b1;
      rxd_s     <= 1'b1;
      tick_cnt  <= '0;
      os        <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      rxd_meta  <= rxd;
      rxd_s     <= rxd_meta;
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      // Consumption; a same-cycle completion below overrides this clear.
      if (rx_valid && rx_if.rx_ready) rx_valid <= 1'b0;

      if (tick) begin
        tick_cnt <= '0;
        os       <= os + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end

      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            // Align the tick grid to the detected falling edge.
            state    <= S_START;
            tick_cnt <= '0;
            os       <= 4'd0;
          end
        end
        S_START: begin
          if (tick && (os == 4'd7)) begin
            if (rxd_s) begin
              state <= S_IDLE;  // glitch shorter than half a bit
            end else begin
              state   <= S_DATA;
              os      <= 4'd0;
              bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              parity_bad <= 1'b0;
`endif
            end
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift   <= {rxd_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            // Even parity: parity bit equals XOR of the data bits.
            if (rxd_s != ^shift) begin
              frame_err  <= 1'b1;
              parity_bad <= 1'b1;
            end
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (rxd_s) begin
              state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (!parity_bad) begin
`else
              begin
`endif
                if (!rx_valid || rx_if.rx_ready) begin
                  rx_data  <= shift;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          // A held-low line (break) must return high before a new start.
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
